// File: rtl/wb_slave_mux.sv
// Wishbone single-master to four-slave multiplexer.
// Decodes on the top address nibble, times out silent slaves, and answers unmapped addresses with an error.
module wb_slave_mux #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  m_adr_i,
    input  logic [31:0]  m_dat_i,
    input  logic [3:0]   m_sel_i,
    input  logic         m_we_i,
    input  logic         m_cyc_i,
    input  logic         m_stb_i,
    output logic [31:0]  m_dat_o,
    output logic         m_ack_o,
    output logic         m_err_o,
    output logic [3:0]   s_cyc_o,
    output logic [3:0]   s_stb_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_sel_o,
    output logic         s_we_o,
    input  logic [127:0] s_dat_i,
    input  logic [3:0]   s_ack_i
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] adr_p0;
    logic [31:0] dat_p0;
    logic [3:0]  sel_p0;
    logic        we_p0;
    logic [1:0]  idx_p0;
    logic        err_p0;
    logic [7:0]  tmo_cnt;
    logic [31:0] rdat_p0;

    logic        req;
    logic        mapped;
    logic [1:0]  idx_dec;
    logic        ack_sel;
    logic        tmo_hit;

    function automatic logic [3:0] one_hot(input logic [1:0] k);
        logic [3:0] v;
        v    = 4'b0000;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] slave_rdata(input logic [127:0] d, input logic [1:0] k);
        logic [31:0] v;
        case (k)
            2'd0:    v = d[31:0];
            2'd1:    v = d[63:32];
            2'd2:    v = d[95:64];
            default: v = d[127:96];
        endcase
        return v;
    endfunction

    assign req     = m_cyc_i & m_stb_i;
    assign mapped  = (m_adr_i[31:30] == 2'b00);
    assign idx_dec = m_adr_i[29:28];
    assign ack_sel = s_ack_i[idx_p0];
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = mapped ? BUSY : RESP;
                end
            end
            BUSY: begin
                // An abort takes precedence over any ack seen in the same cycle.
                if (!m_cyc_i) begin
                    state_nxt = IDLE;
                end else if (ack_sel || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o = 4'b0000;
        s_stb_o = 4'b0000;
        s_adr_o = adr_p0;
        s_dat_o = dat_p0;
        s_sel_o = sel_p0;
        s_we_o  = we_p0;
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        m_dat_o = rdat_p0;
        case (state)
            BUSY: begin
                s_cyc_o = one_hot(idx_p0);
                s_stb_o = one_hot(idx_p0);
            end
            RESP: begin
                m_ack_o = 1'b1;
                m_err_o = err_p0;
            end
            default: ;
        endcase
    end

    // Request latch, timeout counter and response data register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adr_p0  <= 32'h0;
            dat_p0  <= 32'h0;
            sel_p0  <= 4'h0;
            we_p0   <= 1'b0;
            idx_p0  <= 2'd0;
            err_p0  <= 1'b0;
            tmo_cnt <= 8'd0;
            rdat_p0 <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        adr_p0  <= m_adr_i;
                        dat_p0  <= m_dat_i;
                        sel_p0  <= m_sel_i;
                        we_p0   <= m_we_i;
                        idx_p0  <= idx_dec;
                        tmo_cnt <= 8'd0;
                        err_p0  <= !mapped;
                        if (!mapped) begin
                            rdat_p0 <= 32'h0;
                        end
                    end
                end
                BUSY: begin
                    if (m_cyc_i) begin
                        if (ack_sel) begin
                            rdat_p0 <= we_p0 ? 32'h0 : slave_rdata(s_dat_i, idx_p0);
                            err_p0  <= 1'b0;
                        end else if (tmo_hit) begin
                            rdat_p0 <= 32'h0;
                            err_p0  <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux with a short timeout so silent-slave cases finish quickly.
module tb_wb_slave_mux;

    logic         clk;
    logic         reset_n;
    logic [31:0]  m_adr_i;
    logic [31:0]  m_dat_i;
    logic [3:0]   m_sel_i;
    logic         m_we_i;
    logic         m_cyc_i;
    logic         m_stb_i;
    logic [31:0]  m_dat_o;
    logic         m_ack_o;
    logic         m_err_o;
    logic [3:0]   s_cyc_o;
    logic [3:0]   s_stb_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i;

    int checks = 0;
    int errors = 0;

    wb_slave_mux #(.TIMEOUT_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
        m_adr_i = adr;
        m_dat_i = dat;
        m_sel_i = sel;
        m_we_i  = we;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
    endtask

    task automatic drop();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        m_adr_i = 32'h0;
        m_dat_i = 32'h0;
        m_sel_i = 4'h0;
        m_we_i  = 1'b0;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        s_dat_i = 128'h0;
        s_ack_i = 4'h0;

        step();
        step();
        sample();
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_dat", m_dat_o, 0);
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_stb", s_stb_o, 0);
        chk("rst_adr", s_adr_o, 0);
        step();
        reset_n = 1'b1;

        // read slave 1, ack two cycles after strobe
        step();
        req(32'h1000_0004, 32'h0, 4'hF, 1'b0);
        sample();
        chk("rd_idle_stb", s_stb_o, 0);
        step();
        sample();
        chk("rd_stb", s_stb_o, 4'b0010);
        chk("rd_cyc", s_cyc_o, 4'b0010);
        chk("rd_adr", s_adr_o, 32'h1000_0004);
        chk("rd_busy_ack", m_ack_o, 0);
        step();
        sample();
        chk("rd_busy2_ack", m_ack_o, 0);
        step();
        s_ack_i = 4'b0010;
        s_dat_i = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
        sample();
        step();
        s_ack_i = 4'b0000;
        drop();
        sample();
        chk("rd_ack", m_ack_o, 1);
        chk("rd_err", m_err_o, 0);
        chk("rd_dat", m_dat_o, 32'hCAFE_F00D);
        chk("rd_resp_stb", s_stb_o, 0);

        // unmapped access, then a write presented during RESP
        step();
        req(32'h8000_0000, 32'h0, 4'hF, 1'b0);
        sample();
        chk("unm_stb", s_stb_o, 0);
        chk("unm_hold_dat", m_dat_o, 32'hCAFE_F00D);
        step();
        req(32'h3000_0000, 32'h1234_5678, 4'b0011, 1'b1);
        sample();
        chk("unm_ack", m_ack_o, 1);
        chk("unm_err", m_err_o, 1);
        chk("unm_dat", m_dat_o, 0);
        chk("unm_resp_stb", s_stb_o, 0);
        step();
        sample();
        chk("b2b_idle_ack", m_ack_o, 0);
        chk("b2b_idle_err", m_err_o, 0);

        // write to slave 3; master fields change during BUSY and must be ignored
        step();
        m_adr_i = 32'h1000_0000;
        m_dat_i = 32'hFFFF_FFFF;
        m_sel_i = 4'hF;
        m_we_i  = 1'b0;
        sample();
        chk("wr_stb", s_stb_o, 4'b1000);
        chk("wr_cyc", s_cyc_o, 4'b1000);
        chk("wr_we", s_we_o, 1);
        chk("wr_sdat", s_dat_o, 32'h1234_5678);
        chk("wr_sel", s_sel_o, 4'b0011);
        chk("wr_adr", s_adr_o, 32'h3000_0000);
        step();
        s_ack_i = 4'b1000;
        s_dat_i = {32'hDEAD_BEEF, 96'h0};
        sample();
        step();
        s_ack_i = 4'b0000;
        drop();
        sample();
        chk("wr_ack", m_ack_o, 1);
        chk("wr_err", m_err_o, 0);
        chk("wr_dat", m_dat_o, 0);
        step();
        s_ack_i = 4'hF;
        sample();
        chk("idle_ack_ignored", m_ack_o, 0);

        // slave 2 selected; a stray ack from slave 0 must not complete it
        step();
        s_ack_i = 4'h0;
        req(32'h2000_0008, 32'h0, 4'hF, 1'b0);
        sample();
        step();
        s_ack_i = 4'b0001;
        s_dat_i = {32'h0, 32'h5A5A_1234, 32'h0, 32'h1111_1111};
        sample();
        chk("s2_stb", s_stb_o, 4'b0100);
        step();
        sample();
        chk("s2_stray_ack", m_ack_o, 0);
        chk("s2_still_busy", s_stb_o, 4'b0100);
        step();
        s_ack_i = 4'b0100;
        sample();
        step();
        s_ack_i = 4'b0000;
        drop();
        sample();
        chk("s2_ack", m_ack_o, 1);
        chk("s2_err", m_err_o, 0);
        chk("s2_dat", m_dat_o, 32'h5A5A_1234);

        // silent slave 0: four BUSY cycles, then error
        step();
        req(32'h0000_0100, 32'h0, 4'hF, 1'b0);
        sample();
        for (int i = 0; i < 4; i++) begin
            step();
            sample();
            chk($sformatf("tmo_busy%0d_stb", i), s_stb_o, 4'b0001);
            chk($sformatf("tmo_busy%0d_ack", i), m_ack_o, 0);
        end
        step();
        drop();
        sample();
        chk("tmo_ack", m_ack_o, 1);
        chk("tmo_err", m_err_o, 1);
        chk("tmo_dat", m_dat_o, 0);
        chk("tmo_stb", s_stb_o, 0);

        // ack in the final timeout cycle wins
        step();
        req(32'h1000_0000, 32'h0, 4'hF, 1'b0);
        s_dat_i = {32'h0, 32'h0, 32'h600D_F00D, 32'h0};
        sample();
        for (int i = 0; i < 3; i++) begin
            step();
            sample();
            chk($sformatf("race_busy%0d_ack", i), m_ack_o, 0);
        end
        step();
        s_ack_i = 4'b0010;
        sample();
        chk("race_stb", s_stb_o, 4'b0010);
        step();
        s_ack_i = 4'b0000;
        drop();
        sample();
        chk("race_ack", m_ack_o, 1);
        chk("race_err", m_err_o, 0);
        chk("race_dat", m_dat_o, 32'h600D_F00D);

        // master abort in BUSY
        step();
        req(32'h1000_0000, 32'h0, 4'hF, 1'b0);
        sample();
        step();
        drop();
        sample();
        chk("abort_busy_stb", s_stb_o, 4'b0010);
        step();
        s_ack_i = 4'b0010;
        sample();
        chk("abort_ack", m_ack_o, 0);
        chk("abort_stb", s_stb_o, 0);
        step();
        s_ack_i = 4'b0000;
        sample();
        chk("abort_ack2", m_ack_o, 0);
        chk("abort_hold_dat", m_dat_o, 32'h600D_F00D);

        // reset pulse in BUSY, then first request accepted immediately
        step();
        req(32'h3000_0000, 32'h0, 4'hF, 1'b0);
        sample();
        step();
        sample();
        chk("rstb_stb", s_stb_o, 4'b1000);
        step();
        reset_n = 1'b0;
        sample();
        chk("rstb_async_stb", s_stb_o, 0);
        chk("rstb_async_ack", m_ack_o, 0);
        chk("rstb_async_dat", m_dat_o, 0);
        step();
        reset_n = 1'b1;
        req(32'h0000_0000, 32'h0, 4'hF, 1'b0);
        sample();
        chk("post_rst_idle_stb", s_stb_o, 0);
        chk("post_rst_idle_ack", m_ack_o, 0);
        step();
        s_ack_i = 4'b0001;
        s_dat_i = {96'h0, 32'h0BAD_CAFE};
        sample();
        chk("post_rst_stb", s_stb_o, 4'b0001);
        chk("post_rst_adr", s_adr_o, 32'h0000_0000);
        step();
        s_ack_i = 4'b0000;
        drop();
        sample();
        chk("post_rst_ack", m_ack_o, 1);
        chk("post_rst_err", m_err_o, 0);
        chk("post_rst_dat", m_dat_o, 32'h0BAD_CAFE);
        step();
        sample();
        chk("post_rst_ack_single", m_ack_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
